// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array controller.
//   state_e    : controller FSM states
//   CNT_WIDTH  : width of command/beat counters
//   PERF_WIDTH : width of the performance counters
//   psum_width : partial-sum width derived from the operand width
package sys_array_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWload = 2'd1,
        StFeed  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned PERF_WIDTH = 32;

    function automatic int unsigned psum_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/sys_array_ctrl_skew.sv
// skew_line: fixed-latency delay lane used for input skew and output deskew.
//   clk    : clock, posedge
//   rst    : synchronous active-high reset, clears every stage
//   i_data : lane input
//   o_data : lane output, i_data delayed by DEPTH cycles (DEPTH 0 = wire)
module skew_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_pipe[k] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_data;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl: command sequencer for a weight-stationary systolic array.
// Loads SYS_ROW weight rows (unless reused), streams K activation vectors
// through a row skew, deskews the column partial sums and counts K results.
// Optional feature macro: SYS_ARRAY_CTRL_PERF_EN (busy/stall counters).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake (ready only in idle)
//   cmd_num_vec, cmd_reuse_w       : vector count K, keep resident weights
//   cmd_row_mask                   : 1 = row holds a valid weight
//   w_valid/w_ready/w_data         : weight-row stream
//   a_valid/a_ready/a_data         : activation-vector stream
//   arr_*                          : array-side control, data and results
//   res_valid/res_data             : deskewed result row, no backpressure
//   busy, done                     : status, done is a one-cycle pulse
//   perf_busy, perf_stall          : saturating performance counters
module sys_array_ctrl
    import sys_array_pkg::*;
#(
    parameter int unsigned SYS_ROW    = 16,
    parameter int unsigned SYS_COL    = 16,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned PSUM_WIDTH = psum_width(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CNT_WIDTH-1:0]          cmd_num_vec,
    input  logic                          cmd_reuse_w,
    input  logic [SYS_ROW-1:0]            cmd_row_mask,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [SYS_COL*DATA_WIDTH-1:0] w_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [SYS_ROW*DATA_WIDTH-1:0] a_data,
    output logic                          arr_en,
    output logic [SYS_COL-1:0]            arr_w_wen,
    output logic [SYS_ROW-1:0]            arr_w_invalid,
    output logic [SYS_COL*DATA_WIDTH-1:0] arr_w_in,
    output logic [SYS_ROW*DATA_WIDTH-1:0] arr_in,
    input  logic [SYS_COL*PSUM_WIDTH-1:0] arr_psum_out,
    input  logic [SYS_COL-1:0]            arr_en_out,
    output logic                          res_valid,
    output logic [SYS_COL*PSUM_WIDTH-1:0] res_data,
    output logic                          busy,
    output logic                          done,
    output logic [PERF_WIDTH-1:0]         perf_busy,
    output logic [PERF_WIDTH-1:0]         perf_stall
);

    localparam logic [CNT_WIDTH-1:0] ROW_BEATS = CNT_WIDTH'(SYS_ROW);

    state_e               r_state;
    state_e               w_state_d;
    logic [CNT_WIDTH-1:0] r_num_vec;
    logic [SYS_ROW-1:0]   r_row_mask;
    logic [CNT_WIDTH-1:0] r_wcnt;
    logic [CNT_WIDTH-1:0] r_acnt;
    logic [CNT_WIDTH-1:0] r_rcnt;

    logic                 w_cmd_fire;
    logic                 w_w_fire;
    logic                 w_a_fire;
    logic [CNT_WIDTH-1:0] w_wcnt_inc;
    logic [CNT_WIDTH-1:0] w_acnt_inc;
    logic [SYS_ROW-1:0]   w_lane_vld;
    logic [SYS_COL-1:0]   w_col_vld;

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_w_fire   = w_valid & w_ready;
    assign w_a_fire   = a_valid & a_ready;
    assign w_wcnt_inc = r_wcnt + 1'b1;
    assign w_acnt_inc = r_acnt + 1'b1;

    // Next-state and handshake decode.
    always_comb begin
        w_state_d = r_state;
        cmd_ready = 1'b0;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        arr_w_wen = '0;
        done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // K=0 goes straight to drain, whose count already matches.
                    if (cmd_num_vec == '0) begin
                        w_state_d = StDrain;
                    end else if (cmd_reuse_w) begin
                        w_state_d = StFeed;
                    end else begin
                        w_state_d = StWload;
                    end
                end
            end
            StWload: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    arr_w_wen = '1;
                    if (w_wcnt_inc == ROW_BEATS) begin
                        w_state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                a_ready = 1'b1;
                if (a_valid && (w_acnt_inc == r_num_vec)) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_rcnt == r_num_vec) begin
                    done      = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_num_vec  <= '0;
            r_row_mask <= '0;
            r_wcnt     <= '0;
            r_acnt     <= '0;
            r_rcnt     <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_cmd_fire) begin
                r_num_vec  <= cmd_num_vec;
                r_row_mask <= cmd_row_mask;
                r_wcnt     <= '0;
                r_acnt     <= '0;
                r_rcnt     <= '0;
            end else begin
                if (w_w_fire) begin
                    r_wcnt <= w_wcnt_inc;
                end
                if (w_a_fire) begin
                    r_acnt <= w_acnt_inc;
                end
                // Results may start arriving while still feeding.
                if (busy && res_valid && (r_rcnt != '1)) begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end
    end

    assign busy          = (r_state != StIdle);
    assign arr_w_in      = w_data;
    assign arr_w_invalid = ~r_row_mask;

    // Input skew: row i delayed i cycles; the extra bit marks a real beat.
    for (genvar i = 0; i < SYS_ROW; i++) begin : g_skew
        logic [DATA_WIDTH:0] w_lane_o;

        skew_line #(
            .WIDTH(DATA_WIDTH + 1),
            .DEPTH(i)
        ) u_skew (
            .clk   (clk),
            .rst   (rst),
            .i_data({w_a_fire, w_a_fire ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0}),
            .o_data(w_lane_o)
        );

        assign arr_in[i*DATA_WIDTH +: DATA_WIDTH] = w_lane_o[DATA_WIDTH-1:0];
        assign w_lane_vld[i]                      = w_lane_o[DATA_WIDTH];
    end

    assign arr_en = |w_lane_vld;

    // Output deskew: column j delayed (SYS_COL-1-j) cycles so a row lines up.
    for (genvar j = 0; j < SYS_COL; j++) begin : g_deskew
        logic [PSUM_WIDTH:0] w_col_o;

        skew_line #(
            .WIDTH(PSUM_WIDTH + 1),
            .DEPTH(SYS_COL - 1 - j)
        ) u_deskew (
            .clk   (clk),
            .rst   (rst),
            .i_data({arr_en_out[j], arr_psum_out[j*PSUM_WIDTH +: PSUM_WIDTH]}),
            .o_data(w_col_o)
        );

        assign w_col_vld[j] = w_col_o[PSUM_WIDTH];
        // Columns without a valid result are zeroed rather than passing junk.
        assign res_data[j*PSUM_WIDTH +: PSUM_WIDTH] =
            w_col_vld[j] ? w_col_o[PSUM_WIDTH-1:0] : '0;
    end

    assign res_valid = w_col_vld[SYS_COL-1];

`ifdef SYS_ARRAY_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] r_perf_busy;
    logic [PERF_WIDTH-1:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (busy && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 1'b1;
            end
            if ((r_state == StFeed) && !a_valid && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_busy  = r_perf_busy;
    assign perf_stall = r_perf_stall;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl (4x4 array, 8-bit operands) with a
// behavioural weight-stationary array model closing the loop.
module tb_sys_array_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_num_vec;
    logic        cmd_reuse_w;
    logic [3:0]  cmd_row_mask;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        arr_en;
    logic [3:0]  arr_w_wen;
    logic [3:0]  arr_w_invalid;
    logic [31:0] arr_w_in;
    logic [31:0] arr_in;
    logic [63:0] arr_psum_out;
    logic [3:0]  arr_en_out;
    logic        res_valid;
    logic [63:0] res_data;
    logic        busy;
    logic        done;
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;

    int checks = 0;
    int errors = 0;

    sys_array_ctrl #(
        .SYS_ROW   (4),
        .SYS_COL   (4),
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num_vec  (cmd_num_vec),
        .cmd_reuse_w  (cmd_reuse_w),
        .cmd_row_mask (cmd_row_mask),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .arr_en       (arr_en),
        .arr_w_wen    (arr_w_wen),
        .arr_w_invalid(arr_w_invalid),
        .arr_w_in     (arr_w_in),
        .arr_in       (arr_in),
        .arr_psum_out (arr_psum_out),
        .arr_en_out   (arr_en_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .busy         (busy),
        .done         (done),
        .perf_busy    (perf_busy),
        .perf_stall   (perf_stall)
    );

    always #5 clk = ~clk;

    // ---------------- array model ----------------
    logic [7:0]  m_w [4][4];
    logic [7:0]  m_a [4][4];
    logic [15:0] m_p [4][4];
    logic [6:0]  m_v;

    function automatic logic [7:0] act_at(int r, int c);
        if (c == 0) return arr_in[r*8 +: 8];
        return m_a[r][c-1];
    endfunction

    function automatic logic [15:0] psum_above(int r, int c);
        if (r == 0) return 16'd0;
        return m_p[r-1][c];
    endfunction

    function automatic logic [15:0] mac(int r, int c);
        logic [7:0] w;
        w = arr_w_invalid[r] ? 8'd0 : m_w[r][c];
        return psum_above(r, c) + ({8'd0, act_at(r, c)} * {8'd0, w});
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (arr_w_wen[c]) begin
                for (int r = 3; r > 0; r--) m_w[r][c] <= m_w[r-1][c];
                m_w[0][c] <= arr_w_in[c*8 +: 8];
            end
        end
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    m_a[r][c] <= 8'd0;
                    m_p[r][c] <= 16'd0;
                end
            end
            m_v <= 7'd0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    m_a[r][c] <= act_at(r, c);
                    m_p[r][c] <= mac(r, c);
                end
            end
            m_v <= {m_v[5:0], a_valid & a_ready};
        end
    end

    assign arr_psum_out = {m_p[3][3], m_p[3][2], m_p[3][1], m_p[3][0]};
    assign arr_en_out   = {m_v[6], m_v[5], m_v[4], m_v[3]};

    // ---------------- monitor ----------------
    logic [63:0] res_q[$];
    int done_cnt, en_cnt, wr_cnt, busy_cnt;

    always @(negedge clk) begin
        if (res_valid) res_q.push_back(res_data);
        if (done) done_cnt++;
        if (arr_en) en_cnt++;
        if (w_ready) wr_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic logic [31:0] p8(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] p16(int a, int b, int c, int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic clear_mon();
        res_q.delete();
        done_cnt = 0;
        en_cnt   = 0;
        wr_cnt   = 0;
        busy_cnt = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic send_cmd(input int k, input logic reuse, input logic [3:0] mask);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_num_vec = 16'(k);
        cmd_reuse_w = reuse;
        cmd_row_mask = mask;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got 0, want 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // wm holds row r at [r*32 +: 32]; bottom row is sent first.
    task automatic load_weights(input logic [127:0] wm);
        for (int r = 3; r >= 0; r--) begin
            int n = 0;
            w_data  = wm[r*32 +: 32];
            w_valid = 1'b1;
            @(negedge clk);
            while (!w_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!w_ready) begin
                checks++; errors++;
                $display("FAIL w_ready_timeout: row %0d got 0, want 1", r);
            end
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
    endtask

    // Two idle a_valid cycles are inserted before beat stall_at (-1 = none).
    task automatic feed(input logic [127:0] vecs, input int n_vec, input int stall_at);
        for (int b = 0; b < n_vec; b++) begin
            int n = 0;
            if (b == stall_at) begin
                a_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            a_data  = vecs[b*32 +: 32];
            a_valid = 1'b1;
            @(negedge clk);
            while (!a_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!a_ready) begin
                checks++; errors++;
                $display("FAIL a_ready_timeout: beat %0d got 0, want 1", b);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done pulse, want one");
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, res_valid, arr_en, w_ready, a_ready} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_status: got %b, want 1000000",
                     {cmd_ready, busy, done, res_valid, arr_en, w_ready, a_ready});
        end
        checks++;
        if (arr_w_invalid !== 4'hF || arr_w_wen !== 4'h0) begin
            errors++;
            $display("FAIL reset_array_ctl: got invalid=%h wen=%h, want F 0",
                     arr_w_invalid, arr_w_wen);
        end
        checks++;
        if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d %0d, want 0 0", perf_busy, perf_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        logic [63:0] exp [3];
        logic [63:0] got;
        exp[0] = p16(1, 2, 3, 4);
        exp[1] = p16(5, 6, 7, 8);
        exp[2] = p16(9, 10, 11, 12);
        clear_mon();
        send_cmd(3, 1'b0, 4'hF);
        load_weights({p8(0, 0, 0, 1), p8(0, 0, 1, 0), p8(0, 1, 0, 0), p8(1, 0, 0, 0)});
        feed({32'd0, p8(9, 10, 11, 12), p8(5, 6, 7, 8), p8(1, 2, 3, 4)}, 3, -1);
        wait_done();
        checks++;
        if (res_q.size() != 3) begin
            errors++;
            $display("FAIL identity_count: got %0d, want 3", res_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 64'hx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL identity_res%0d: got %h, want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || en_cnt != 6 || wr_cnt != 4) begin
            errors++;
            $display("FAIL identity_ctl: got done=%0d en=%0d wready=%0d, want 1 6 4",
                     done_cnt, en_cnt, wr_cnt);
        end
    endtask

    task automatic test_reuse();
        logic [63:0] exp [2];
        logic [63:0] got;
        exp[0] = p16(10, 20, 30, 40);
        exp[1] = p16(255, 1, 2, 3);
        clear_mon();
        send_cmd(2, 1'b1, 4'hF);
        feed({64'd0, p8(255, 1, 2, 3), p8(10, 20, 30, 40)}, 2, -1);
        wait_done();
        checks++;
        if (res_q.size() != 2) begin
            errors++;
            $display("FAIL reuse_count: got %0d, want 2", res_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 64'hx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL reuse_res%0d: got %h, want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (wr_cnt != 0 || done_cnt != 1 || en_cnt != 5) begin
            errors++;
            $display("FAIL reuse_ctl: got wready=%0d done=%0d en=%0d, want 0 1 5",
                     wr_cnt, done_cnt, en_cnt);
        end
    endtask

    task automatic test_zero();
        clear_mon();
        send_cmd(0, 1'b0, 4'hF);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done_now: got %b, want 1", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_back_idle: got done=%b ready=%b, want 0 1", done, cmd_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (en_cnt != 0 || wr_cnt != 0 || done_cnt != 1 || res_q.size() != 0) begin
            errors++;
            $display("FAIL zero_ctl: got en=%0d wready=%0d done=%0d res=%0d, want 0 0 1 0",
                     en_cnt, wr_cnt, done_cnt, res_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mask();
        logic [63:0] got;
        clear_mon();
        send_cmd(1, 1'b0, 4'b0111);
        checks++;
        if (arr_w_invalid !== 4'b1000) begin
            errors++;
            $display("FAIL mask_accept: got %b, want 1000", arr_w_invalid);
        end
        load_weights({p8(2, 2, 2, 2), p8(2, 2, 2, 2), p8(2, 2, 2, 2), p8(2, 2, 2, 2)});
        feed({96'd0, p8(3, 5, 7, 100)}, 1, -1);
        wait_done();
        got = (res_q.size() > 0) ? res_q[0] : 64'hx;
        checks++;
        if (res_q.size() != 1 || got !== p16(30, 30, 30, 30)) begin
            errors++;
            $display("FAIL mask_res: got n=%0d %h, want 1 %h", res_q.size(), got,
                     p16(30, 30, 30, 30));
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (arr_w_invalid !== 4'b1000) begin
            errors++;
            $display("FAIL mask_hold: got %b, want 1000", arr_w_invalid);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp [4];
        logic [63:0] got;
        logic [31:0] stall0, busy0, exp_stall, exp_busy;
        exp[0] = p16(1, 2, 3, 4);
        exp[1] = p16(5, 6, 7, 8);
        exp[2] = p16(28, 32, 36, 40);
        exp[3] = p16(41, 46, 51, 56);
        stall0 = perf_stall;
        busy0  = perf_busy;
        clear_mon();
        send_cmd(4, 1'b0, 4'hF);
        checks++;
        if (arr_w_invalid !== 4'b0000) begin
            errors++;
            $display("FAIL mask_next_cmd: got %b, want 0000", arr_w_invalid);
        end
        load_weights({p8(13, 14, 15, 16), p8(9, 10, 11, 12), p8(5, 6, 7, 8), p8(1, 2, 3, 4)});
        feed({p8(2, 0, 0, 3), p8(1, 1, 1, 1), p8(0, 1, 0, 0), p8(1, 0, 0, 0)}, 4, 2);
        wait_done();
        checks++;
        if (res_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d, want 4", res_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 64'hx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL stall_res%0d: got %h, want %h", i, got, exp[i]);
            end
        end
        checks++;
        if (en_cnt != 9 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_ctl: got en=%0d done=%0d, want 9 1", en_cnt, done_cnt);
        end
`ifdef SYS_ARRAY_CTRL_PERF_EN
        exp_stall = 32'd2;
        exp_busy  = 32'(busy_cnt);
`else
        exp_stall = 32'd0;
        exp_busy  = 32'd0;
`endif
        checks++;
        if (perf_stall - stall0 !== exp_stall) begin
            errors++;
            $display("FAIL perf_stall: got %0d, want %0d", perf_stall - stall0, exp_stall);
        end
        checks++;
        if (perf_busy - busy0 !== exp_busy) begin
            errors++;
            $display("FAIL perf_busy: got %0d, want %0d", perf_busy - busy0, exp_busy);
        end
    endtask

    task automatic test_reset_mid_feed();
        int n = 0;
        logic [63:0] got;
        clear_mon();
        send_cmd(3, 1'b0, 4'hF);
        load_weights({p8(0, 0, 0, 1), p8(0, 0, 1, 0), p8(0, 1, 0, 0), p8(1, 0, 0, 0)});
        a_data  = p8(7, 7, 7, 7);
        a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, res_valid, arr_en, a_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_mid_status: got %b, want 10000",
                     {cmd_ready, busy, res_valid, arr_en, a_ready});
        end
        checks++;
        if (arr_w_invalid !== 4'hF || perf_busy !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_regs: got invalid=%h busy=%0d stall=%0d, want F 0 0",
                     arr_w_invalid, perf_busy, perf_stall);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (res_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got res=%0d done=%0d, want 0 0",
                     res_q.size(), done_cnt);
        end
        clear_mon();
        send_cmd(1, 1'b0, 4'hF);
        load_weights({p8(13, 14, 15, 16), p8(9, 10, 11, 12), p8(5, 6, 7, 8), p8(1, 2, 3, 4)});
        feed({96'd0, p8(1, 1, 1, 1)}, 1, -1);
        wait_done();
        got = (res_q.size() > 0) ? res_q[0] : 64'hx;
        checks++;
        if (res_q.size() != 1 || got !== p16(28, 32, 36, 40)) begin
            errors++;
            $display("FAIL rst_mid_fresh: got n=%0d %h, want 1 %h", res_q.size(), got,
                     p16(28, 32, 36, 40));
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_num_vec = 16'd0;
        cmd_reuse_w = 1'b0;
        cmd_row_mask = 4'h0;
        w_valid = 1'b0;
        w_data = 32'd0;
        a_valid = 1'b0;
        a_data = 32'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) m_w[r][c] = 8'd0;
        end
        clear_mon();
        test_reset();
        test_identity();
        test_reuse();
        test_zero();
        test_mask();
        test_stall();
        test_reset_mid_feed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
